// File: rtl/count_ctrl_pkg.sv
//==============================================================================
// Module : count_ctrl_pkg
// Brief  : Shared state encoding, digit constants and counter-width helper
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package count_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_PAUSE = 2'd0,
      ST_RUN   = 2'd1,
      ST_EDIT  = 2'd2
   } state_t;

   localparam int         NUM_DIGITS = 8;
   localparam logic [3:0] BCD_MAX    = 4'd9;

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
      return (v > BCD_MAX) ? BCD_MAX : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/count_seq_ctrl_if.sv
//==============================================================================
// Module : count_seq_ctrl_if
// Brief  : Control strobes from the mode sequencer to the counter datapath
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface count_seq_ctrl_if;
   logic       cnt_en;
   logic       cnt_ud;
   logic       cnt_load;
   logic [2:0] cnt_numsel;
   logic [3:0] cnt_digit;

   modport master (output cnt_en, cnt_ud, cnt_load, cnt_numsel, cnt_digit);
   modport slave  (input  cnt_en, cnt_ud, cnt_load, cnt_numsel, cnt_digit);
endinterface

`default_nettype wire

// File: rtl/count_seq_ctrl_tick_div.sv
//==============================================================================
// Module : tick_div
// Brief  : Modulo-N counter with synchronous clear/enable and a wrap pulse
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tick_div
   import count_ctrl_pkg::*;
#(
   parameter int N = 4
) (
   input  wire logic clk1,
   input  wire logic rst1,
   input  wire logic i_clr,
   input  wire logic i_en,
   output logic      o_wrap
);

   localparam int             c_W    = cnt_width(N);
   localparam logic [c_W-1:0] c_LAST = c_W'(N - 1);

   logic [c_W-1:0] r_cnt;
   logic           w_last;

   assign w_last = (r_cnt == c_LAST);
   // Clear dominates so a restart never produces a stray wrap pulse
   assign o_wrap = i_en & ~i_clr & w_last;

   always_ff @(posedge clk1) begin
      if (!rst1) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/count_seq_ctrl.sv
//==============================================================================
// Module : count_seq_ctrl
// Brief  : RUN/PAUSE/EDIT sequencer producing counter control strobes.
//          Optional digit blink enabled by defining COUNT_BLINK_EN.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module count_seq_ctrl
   import count_ctrl_pkg::*;
#(
   parameter int TICK_DIV  = 100_000_000,
   parameter int BLINK_DIV = 25_000_000
) (
   input  wire logic       clk1,
   input  wire logic       rst1,
   input  wire logic       btn_mode,
   input  wire logic       btn_next,
   input  wire logic       btn_load,
   input  wire logic       sw_dir,
   input  wire logic [3:0] sw_val,
   count_seq_ctrl_if.master cnt,
   output logic [1:0]      state_o,
   output logic [7:0]      blank_mask
);

   if (TICK_DIV < 2 || BLINK_DIV < 2) begin : g_param_check
      $error("count_seq_ctrl: TICK_DIV and BLINK_DIV must be at least 2");
   end

   logic       r_mode_q, r_next_q, r_load_q;
   logic       w_mode_e, w_next_e, w_load_e;
   state_t     r_state, w_state_nxt;
   logic       r_en, r_ud, r_load;
   logic [2:0] r_numsel;
   logic [3:0] r_digit;
   logic       w_en_nxt, w_ud_nxt, w_load_nxt;
   logic [2:0] w_numsel_nxt;
   logic [3:0] w_digit_nxt;
   logic       w_tick, w_run_entry;

   assign w_mode_e = btn_mode & ~r_mode_q;
   assign w_next_e = btn_next & ~r_next_q;
   assign w_load_e = btn_load & ~r_load_q;

   assign w_run_entry = (r_state != ST_RUN) && (w_state_nxt == ST_RUN);

   tick_div #(.N(TICK_DIV)) u_tick (
      .clk1   (clk1),
      .rst1   (rst1),
      .i_clr  (w_run_entry),
      .i_en   (r_state == ST_RUN),
      .o_wrap (w_tick)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_en_nxt     = 1'b0;
      w_load_nxt   = 1'b0;
      w_ud_nxt     = r_ud;
      w_numsel_nxt = r_numsel;
      w_digit_nxt  = r_digit;
      case (r_state)
         ST_PAUSE: begin
            if (w_mode_e) begin
               w_state_nxt = ST_RUN;
            end else if (w_next_e) begin
               w_state_nxt  = ST_EDIT;
               w_numsel_nxt = 3'd0;
               w_ud_nxt     = 1'b0;
            end
         end
         ST_RUN: begin
            // A tick due on the same cycle as a mode edge is still emitted
            if (w_tick) begin
               w_en_nxt = 1'b1;
               w_ud_nxt = sw_dir;
            end
            if (w_mode_e) begin
               w_state_nxt = ST_PAUSE;
            end
         end
         ST_EDIT: begin
            if (w_mode_e) begin
               w_state_nxt = ST_PAUSE;
            end else if (w_load_e) begin
               w_en_nxt    = 1'b1;
               w_load_nxt  = 1'b1;
               w_ud_nxt    = 1'b0;
               w_digit_nxt = bcd_clamp(sw_val);
            end else if (w_next_e) begin
               w_numsel_nxt = r_numsel + 3'd1;
            end
         end
         default: begin
            w_state_nxt = ST_PAUSE;
         end
      endcase
   end

   always_ff @(posedge clk1) begin
      if (!rst1) begin
         r_mode_q <= 1'b0;
         r_next_q <= 1'b0;
         r_load_q <= 1'b0;
         r_state  <= ST_PAUSE;
         r_en     <= 1'b0;
         r_ud     <= 1'b0;
         r_load   <= 1'b0;
         r_numsel <= 3'd0;
         r_digit  <= 4'd0;
      end else begin
         r_mode_q <= btn_mode;
         r_next_q <= btn_next;
         r_load_q <= btn_load;
         r_state  <= w_state_nxt;
         r_en     <= w_en_nxt;
         r_ud     <= w_ud_nxt;
         r_load   <= w_load_nxt;
         r_numsel <= w_numsel_nxt;
         r_digit  <= w_digit_nxt;
      end
   end

   assign cnt.cnt_en     = r_en;
   assign cnt.cnt_ud     = r_ud;
   assign cnt.cnt_load   = r_load;
   assign cnt.cnt_numsel = r_numsel;
   assign cnt.cnt_digit  = r_digit;
   assign state_o        = r_state;

`ifdef COUNT_BLINK_EN
   logic       w_blink_restart, w_blink_wrap, r_phase, w_phase_nxt;
   logic [7:0] r_blank;

   // Blink restarts, digit visible, whenever a new digit comes under edit
   assign w_blink_restart = (w_state_nxt == ST_EDIT) &&
                            ((r_state != ST_EDIT) || (w_numsel_nxt != r_numsel));
   assign w_phase_nxt     = w_blink_restart ? 1'b0 :
                            (w_blink_wrap ? ~r_phase : r_phase);

   tick_div #(.N(BLINK_DIV)) u_blink (
      .clk1   (clk1),
      .rst1   (rst1),
      .i_clr  (w_blink_restart),
      .i_en   (r_state == ST_EDIT),
      .o_wrap (w_blink_wrap)
   );

   always_ff @(posedge clk1) begin
      if (!rst1) begin
         r_phase <= 1'b0;
         r_blank <= 8'h00;
      end else begin
         r_phase <= w_phase_nxt;
         r_blank <= ((w_state_nxt == ST_EDIT) && w_phase_nxt) ?
                    (8'b1 << w_numsel_nxt) : 8'h00;
      end
   end

   assign blank_mask = r_blank;
`else
   assign blank_mask = 8'h00;
`endif

endmodule

`default_nettype wire
